// File: rtl/bcd_clock_core.sv
// rtl/bcd_clock_core.sv - HH:MM:SS BCD timekeeping core with 1 Hz prescaler,
// two-button set mode and blinking of the field being edited.
module bcd_clock_core #(
  parameter int CLK_RATE_HZ        = 390625,
  parameter int BLINK_RATE_HZ      = 2,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [23:0] time_bcd,
  output logic [5:0]  digit_enable_mask,
  output logic        second_tick,
  output logic        set_active
);

  localparam int PW       = (CLK_RATE_HZ > 1) ? $clog2(CLK_RATE_HZ) : 1;
  localparam int HALF_RAW = CLK_RATE_HZ / (2 * BLINK_RATE_HZ);
  localparam int HALF     = (HALF_RAW > 0) ? HALF_RAW : 1;
  localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_RATE_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  localparam logic [1:0] RUN         = 2'd0;
  localparam logic [1:0] SET_HOURS   = 2'd1;
  localparam logic [1:0] SET_MINUTES = 2'd2;

  logic [1:0]    state, state_next;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          tick;
  logic [23:0]   time_next;
  logic [5:0]    mask_next;

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick = (state == RUN) && (presc == PRESC_MAX);

  always_comb begin
    state_next = state;
    time_next  = time_bcd;
    case (state)
      RUN: begin
        if (tick) begin
          time_next[7:0] = inc_mod60(time_bcd[7:0]);
          if (time_bcd[7:0] == 8'h59) begin
            time_next[15:8] = inc_mod60(time_bcd[15:8]);
            if (time_bcd[15:8] == 8'h59)
              time_next[23:16] = inc_mod24(time_bcd[23:16]);
          end
        end
        if (btn_mode)
          state_next = SET_HOURS;
      end
      SET_HOURS: begin
        if (btn_mode)
          state_next = SET_MINUTES;
        else if (btn_inc)
          time_next[23:16] = inc_mod24(time_bcd[23:16]);
      end
      SET_MINUTES: begin
        if (btn_mode) begin
          state_next     = RUN;
          time_next[7:0] = 8'h00;
        end else if (btn_inc) begin
          time_next[15:8] = inc_mod60(time_bcd[15:8]);
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Blink masking uses the registered phase, so it lands one cycle after a phase change;
  // leading-zero blanking follows the new hours so it stays aligned with time_bcd.
  always_comb begin
    mask_next = 6'b111111;
    if (BLANK_LEADING_ZERO && (time_next[23:20] == 4'd0))
      mask_next[5] = 1'b0;
    if (!blink_on) begin
      if (state == SET_HOURS)
        mask_next[5:4] = 2'b00;
      else if (state == SET_MINUTES)
        mask_next[3:2] = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      presc             <= '0;
      blink_cnt         <= '0;
      blink_on          <= 1'b1;
      time_bcd          <= 24'h000000;
      second_tick       <= 1'b0;
      set_active        <= 1'b0;
      digit_enable_mask <= BLANK_LEADING_ZERO ? 6'b011111 : 6'b111111;
    end else begin
      state             <= state_next;
      time_bcd          <= time_next;
      second_tick       <= tick;
      set_active        <= (state_next != RUN);
      digit_enable_mask <= mask_next;

      if ((state != RUN) || btn_mode || tick)
        presc <= '0;
      else
        presc <= presc + 1'b1;

      if ((state == RUN) || btn_mode || btn_inc) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_clock_core.sv
// tb/tb_bcd_clock_core.sv - self-checking bench for bcd_clock_core against a
// seconds-of-day behavioural model plus hand-computed literal expectations.
module tb_bcd_clock_core;

  localparam int CLK_HZ   = 8;
  localparam int BLINK_HZ = 2;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] time_bcd;
  logic [5:0]  digit_enable_mask;
  logic        second_tick;
  logic        set_active;

  bcd_clock_core #(
    .CLK_RATE_HZ(CLK_HZ),
    .BLINK_RATE_HZ(BLINK_HZ),
    .BLANK_LEADING_ZERO(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .time_bcd(time_bcd),
    .digit_enable_mask(digit_enable_mask),
    .second_tick(second_tick),
    .set_active(set_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: mode 0=RUN 1=SET_HOURS 2=SET_MINUTES; time kept as integers.
  int m_h, m_m, m_s, m_psc, m_mode, m_bcnt;
  bit m_on, m_tick;
  logic [5:0] m_mask;

  function automatic logic [23:0] m_bcd();
    return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit md, input bit inc);
    int old_mode;
    bit old_on;
    bit t;
    int sod;
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_psc = 0; m_mode = 0;
      m_bcnt = 0; m_on = 1'b1; m_tick = 1'b0; m_mask = 6'b011111;
      return;
    end
    old_mode = m_mode;
    old_on   = m_on;
    t = (m_mode == 0) && (m_psc == CLK_HZ - 1);
    if (t) begin
      sod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = sod / 3600;
      m_m = (sod / 60) % 60;
      m_s = sod % 60;
    end
    if (m_mode == 1 && !md && inc) m_h = (m_h + 1) % 24;
    if (m_mode == 2 && !md && inc) m_m = (m_m + 1) % 60;
    if (m_mode == 2 && md) m_s = 0;
    m_psc = (m_mode != 0 || md || t) ? 0 : m_psc + 1;
    if (m_mode == 0 || md || inc) begin
      m_bcnt = 0; m_on = 1'b1;
    end else if (m_bcnt == HALF - 1) begin
      m_bcnt = 0; m_on = !m_on;
    end else begin
      m_bcnt++;
    end
    if (md) m_mode = (m_mode + 1) % 3;
    m_tick = t;
    m_mask = 6'b111111;
    if (m_h < 10) m_mask[5] = 1'b0;
    if (!old_on && old_mode == 1) m_mask[5:4] = 2'b00;
    if (!old_on && old_mode == 2) m_mask[3:2] = 2'b00;
  endtask

  task automatic cyc(input bit rst, input bit md, input bit inc);
    reset = rst;
    btn_mode = md;
    btn_inc = inc;
    @(posedge clk);
    #1;
    model_step(rst, md, inc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_time_bcd", 32'(time_bcd), 32'(m_bcd()));
      chk("cyc_mask", 32'(digit_enable_mask), 32'(m_mask));
      chk("cyc_second_tick", 32'(second_tick), 32'(m_tick));
      chk("cyc_set_active", 32'(set_active), 32'(m_mode != 0));
    end
  end

  logic [1:0] blink_exp [8];

  initial begin
    blink_exp = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};

    // 1: reset values and first tick after CLK_HZ cycles
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_en = 1'b1;
    chk("rst_time", 32'(time_bcd), 32'h000000);
    chk("rst_mask", 32'(digit_enable_mask), 32'b011111);
    chk("rst_set_active", 32'(set_active), 32'd0);
    chk("rst_tick", 32'(second_tick), 32'd0);
    idle(7);
    chk("t1_before_tick", 32'(second_tick), 32'd0);
    chk("t1_time_before", 32'(time_bcd), 32'h000000);
    idle(1);
    chk("t1_time", 32'(time_bcd), 32'h000001);
    chk("t1_tick", 32'(second_tick), 32'd1);
    idle(1);
    chk("t1_tick_drop", 32'(second_tick), 32'd0);

    // 2: reach 23:59:58 through set mode, then roll over midnight
    cyc(1'b0, 1'b1, 1'b0);
    incs(23);
    cyc(1'b0, 1'b1, 1'b0);
    incs(59);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_set_done", 32'(time_bcd), 32'h235900);
    idle(58 * CLK_HZ);
    chk("t2_235958", 32'(time_bcd), 32'h235958);
    idle(CLK_HZ);
    chk("t2_235959", 32'(time_bcd), 32'h235959);
    chk("t2_mask5_on", 32'(digit_enable_mask[5]), 32'd1);
    idle(CLK_HZ);
    chk("t2_midnight", 32'(time_bcd), 32'h000000);
    chk("t2_mask5_off", 32'(digit_enable_mask[5]), 32'd0);

    // 3: hours wrap in SET_HOURS, no ticks
    idle(2 * CLK_HZ);
    cyc(1'b0, 1'b1, 1'b0);
    incs(25);
    chk("t3_hours", 32'(time_bcd), 32'h010002);
    chk("t3_set_active", 32'(set_active), 32'd1);

    // 4: minutes wrap without carry; leaving set zeroes seconds
    cyc(1'b0, 1'b1, 1'b0);
    incs(59);
    chk("t4_min59", 32'(time_bcd), 32'h015902);
    incs(1);
    chk("t4_min_wrap", 32'(time_bcd), 32'h010002);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t4_sec_zero", 32'(time_bcd), 32'h010000);
    idle(7);
    chk("t4_no_tick_yet", 32'(time_bcd), 32'h010000);
    idle(1);
    chk("t4_first_tick", 32'(time_bcd), 32'h010001);
    chk("t4_tick_pulse", 32'(second_tick), 32'd1);

    // 5: blink of hours field
    cyc(1'b0, 1'b1, 1'b0);
    incs(11);
    chk("t5_hours12", 32'(time_bcd), 32'h120001);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk($sformatf("t5_blink_%0d", i), 32'(digit_enable_mask[5:4]), 32'(blink_exp[i]));
    end
    idle(2);
    incs(1);
    chk("t5_inc_off_phase", 32'(digit_enable_mask[5:4]), 32'b00);
    chk("t5_hours13", 32'(time_bcd), 32'h130001);
    idle(1);
    chk("t5_bits_back", 32'(digit_enable_mask[5:4]), 32'b11);
    idle(1);
    chk("t5_bits_hold", 32'(digit_enable_mask[5:4]), 32'b11);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t5_back_run", 32'(time_bcd), 32'h130000);

    // 6: tick with btn_mode, mode+inc together, reset mid-set
    idle(7);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t6_tick_and_mode", 32'(time_bcd), 32'h130001);
    chk("t6_tick_mode_set", 32'(set_active), 32'd1);
    chk("t6_tick_mode_pulse", 32'(second_tick), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t6_modeinc_run", 32'(time_bcd), 32'h130000);
    chk("t6_modeinc_set", 32'(set_active), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t6_modeinc_hours", 32'(time_bcd), 32'h130000);
    incs(2);
    chk("t6_min02", 32'(time_bcd), 32'h130200);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t6_reset_time", 32'(time_bcd), 32'h000000);
    chk("t6_reset_set", 32'(set_active), 32'd0);
    chk("t6_reset_mask", 32'(digit_enable_mask), 32'b011111);
    idle(CLK_HZ);
    chk("t6_after_reset", 32'(time_bcd), 32'h000001);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
